// File: rtl/obi_bank_arbiter.sv
// Round-robin arbiter sharing one OBI RAM bank among NREQ requesters, with an ID FIFO routing responses back.
// Optional contention counter on stall_cnt_o when OBI_BANK_ARB_STALL_CNT_EN is defined.
module obi_bank_arbiter #(
    parameter int NREQ        = 3,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*AW-1:0]    addr_i,
    input  logic [NREQ-1:0]       we_i,
    input  logic [NREQ*DW/8-1:0]  be_i,
    input  logic [NREQ*DW-1:0]    wdata_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic [NREQ-1:0]       rvalid_o,
    output logic [DW-1:0]         rdata_o,
    output logic                  bank_req_o,
    output logic [AW-1:0]         bank_addr_o,
    output logic                  bank_we_o,
    output logic [DW/8-1:0]       bank_be_o,
    output logic [DW-1:0]         bank_wdata_o,
    input  logic                  bank_gnt_i,
    input  logic                  bank_rvalid_i,
    input  logic [DW-1:0]         bank_rdata_i,
    output logic [15:0]           stall_cnt_o
);

    localparam int IDW = $clog2(NREQ);
    localparam int PW  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW  = $clog2(OUTSTANDING + 1);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] rr_win;
    logic           rr_found;
    logic [IDW-1:0] winner;
    logic           locked;
    logic [IDW-1:0] lock_id;

    logic [IDW-1:0] fifo [OUTSTANDING];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [CW-1:0]  count;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    function automatic logic [PW-1:0] fifo_next(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        rr_win   = '0;
        rr_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!rr_found && req_i[rr_idx(ptr, i)]) begin
                rr_found = 1'b1;
                rr_win   = rr_idx(ptr, i);
            end
        end
    end

    // A winner that was offered but not yet granted keeps the bank until granted or it withdraws.
    assign winner = (locked && req_i[lock_id]) ? lock_id : rr_win;

    assign full  = (count == CW'(OUTSTANDING));
    assign empty = (count == '0);

    assign bank_req_o   = ~rst_i & (|req_i) & ~full;
    assign bank_addr_o  = addr_i[winner*AW +: AW];
    assign bank_we_o    = we_i[winner];
    assign bank_be_o    = be_i[winner*(DW/8) +: DW/8];
    assign bank_wdata_o = wdata_i[winner*DW +: DW];

    assign push    = bank_req_o & bank_gnt_i;
    assign pop     = ~rst_i & bank_rvalid_i & ~empty;
    assign rdata_o = bank_rdata_i;

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        if (push) gnt_o[winner] = 1'b1;
        if (pop)  rvalid_o[fifo[head]] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo[tail] <= winner;
        lock_id <= winner;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr    <= '0;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            locked <= 1'b0;
        end else begin
            locked <= bank_req_o & ~bank_gnt_i;
            if (push) begin
                ptr  <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
                tail <= fifo_next(tail);
            end
            if (pop) head <= fifo_next(head);
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

`ifdef OBI_BANK_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if ((|(req_i & ~gnt_o)) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_obi_bank_arbiter.sv
// Directed self-checking bench for obi_bank_arbiter at default parameters (NREQ=3, OUTSTANDING=2).
module tb_obi_bank_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
`ifdef OBI_BANK_ARB_STALL_CNT_EN
    localparam logic [15:0] STALL_EXP = 16'd3;
`else
    localparam logic [15:0] STALL_EXP = 16'd0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic [NREQ-1:0]      req_i;
    logic [NREQ*AW-1:0]   addr_i;
    logic [NREQ-1:0]      we_i;
    logic [NREQ*DW/8-1:0] be_i;
    logic [NREQ*DW-1:0]   wdata_i;
    logic [NREQ-1:0]      gnt_o;
    logic [NREQ-1:0]      rvalid_o;
    logic [DW-1:0]        rdata_o;
    logic                 bank_req_o;
    logic [AW-1:0]        bank_addr_o;
    logic                 bank_we_o;
    logic [DW/8-1:0]      bank_be_o;
    logic [DW-1:0]        bank_wdata_o;
    logic                 bank_gnt_i;
    logic                 bank_rvalid_i;
    logic [DW-1:0]        bank_rdata_i;
    logic [15:0]          stall_cnt_o;

    int checks = 0;
    int errors = 0;

    obi_bank_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .OUTSTANDING(2)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
        .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .bank_req_o(bank_req_o), .bank_addr_o(bank_addr_o),
        .bank_we_o(bank_we_o), .bank_be_o(bank_be_o), .bank_wdata_o(bank_wdata_o),
        .bank_gnt_i(bank_gnt_i), .bank_rvalid_i(bank_rvalid_i),
        .bank_rdata_i(bank_rdata_i), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        req_i         = '0;
        bank_gnt_i    = 1'b0;
        bank_rvalid_i = 1'b0;
        bank_rdata_i  = '0;
    endtask

    task automatic do_reset;
        rst_i = 1'b1;
        idle();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        req_i = 3'b111; bank_gnt_i = 1'b1; bank_rvalid_i = 1'b1;
        #2;
        checks++; if (gnt_o !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b exp 000", gnt_o); end
        checks++; if (rvalid_o !== 3'b000) begin errors++; $display("FAIL reset_rvalid got %b exp 000", rvalid_o); end
        checks++; if (bank_req_o !== 1'b0) begin errors++; $display("FAIL reset_bank_req got %b exp 0", bank_req_o); end
        tick();
        checks++; if (stall_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cnt_o); end
        rst_i = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_round_robin;
        logic [NREQ-1:0] exp_g [4];
        logic [NREQ-1:0] exp_r [5];
        logic [AW-1:0]   exp_a [4];
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
        exp_r[0] = 3'b000; exp_r[1] = 3'b001; exp_r[2] = 3'b010; exp_r[3] = 3'b100; exp_r[4] = 3'b001;
        exp_a[0] = 32'h0000_0A00; exp_a[1] = 32'h0000_0B00; exp_a[2] = 32'h0000_0C00; exp_a[3] = 32'h0000_0A00;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            req_i         = (c < 4) ? 3'b111 : 3'b000;
            bank_gnt_i    = 1'b1;
            bank_rvalid_i = (c > 0);
            bank_rdata_i  = 32'hD000_0000 + c;
            #2;
            if (c < 4) begin
                checks++; if (gnt_o !== exp_g[c]) begin errors++; $display("FAIL rr_gnt c%0d got %b exp %b", c, gnt_o, exp_g[c]); end
                checks++; if (bank_addr_o !== exp_a[c]) begin errors++; $display("FAIL rr_addr c%0d got %h exp %h", c, bank_addr_o, exp_a[c]); end
            end else begin
                checks++; if (gnt_o !== 3'b000) begin errors++; $display("FAIL rr_gnt_idle got %b exp 000", gnt_o); end
            end
            checks++; if (rvalid_o !== exp_r[c]) begin errors++; $display("FAIL rr_rvalid c%0d got %b exp %b", c, rvalid_o, exp_r[c]); end
            if (c == 1) begin
                checks++; if (bank_we_o !== 1'b1) begin errors++; $display("FAIL rr_we got %b exp 1", bank_we_o); end
                checks++; if (bank_be_o !== 4'h3) begin errors++; $display("FAIL rr_be got %h exp 3", bank_be_o); end
                checks++; if (bank_wdata_o !== 32'h1111_0B00) begin errors++; $display("FAIL rr_wdata got %h exp 11110b00", bank_wdata_o); end
                checks++; if (rdata_o !== 32'hD000_0001) begin errors++; $display("FAIL rr_rdata got %h exp d0000001", rdata_o); end
            end
            if (c == 2) begin
                checks++; if (bank_we_o !== 1'b0) begin errors++; $display("FAIL rr_we2 got %b exp 0", bank_we_o); end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_full;
        do_reset();
        req_i = 3'b010; bank_gnt_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #2;
            checks++; if (bank_req_o !== (c < 2)) begin errors++; $display("FAIL full_req c%0d got %b exp %b", c, bank_req_o, (c < 2)); end
            checks++; if (gnt_o !== ((c < 2) ? 3'b010 : 3'b000)) begin errors++; $display("FAIL full_gnt c%0d got %b", c, gnt_o); end
            tick();
        end
        bank_rvalid_i = 1'b1;
        #2;
        checks++; if (rvalid_o !== 3'b010) begin errors++; $display("FAIL full_pop_rvalid got %b exp 010", rvalid_o); end
        checks++; if (bank_req_o !== 1'b0) begin errors++; $display("FAIL full_pop_req got %b exp 0", bank_req_o); end
        tick();
        bank_rvalid_i = 1'b0;
        #2;
        checks++; if (bank_req_o !== 1'b1) begin errors++; $display("FAIL full_reassert got %b exp 1", bank_req_o); end
        checks++; if (gnt_o !== 3'b010) begin errors++; $display("FAIL full_regnt got %b exp 010", gnt_o); end
        tick();
        req_i = '0; bank_rvalid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++; if (rvalid_o !== ((c < 2) ? 3'b010 : 3'b000)) begin errors++; $display("FAIL full_drain c%0d got %b", c, rvalid_o); end
            tick();
        end
        idle();
    endtask

    task automatic test_stall;
        do_reset();
        req_i = 3'b100;
        for (int c = 0; c < 4; c++) begin
            bank_gnt_i = (c == 3);
            #2;
            checks++; if (gnt_o !== ((c == 3) ? 3'b100 : 3'b000)) begin errors++; $display("FAIL stall_gnt c%0d got %b", c, gnt_o); end
            tick();
        end
        req_i = '0; bank_gnt_i = 1'b0; bank_rvalid_i = 1'b1;
        #2;
        checks++; if (stall_cnt_o !== STALL_EXP) begin errors++; $display("FAIL stall_cnt got %0d exp %0d", stall_cnt_o, STALL_EXP); end
        checks++; if (rvalid_o !== 3'b100) begin errors++; $display("FAIL stall_rvalid got %b exp 100", rvalid_o); end
        tick();
        idle();
    endtask

    task automatic test_hold;
        do_reset();
        req_i = 3'b100; bank_gnt_i = 1'b0;
        tick();
        req_i = 3'b101;
        #2;
        checks++; if (bank_addr_o !== 32'h0000_0C00) begin errors++; $display("FAIL hold_addr got %h exp 00000c00", bank_addr_o); end
        tick();
        bank_gnt_i = 1'b1;
        #2;
        checks++; if (gnt_o !== 3'b100) begin errors++; $display("FAIL hold_gnt got %b exp 100", gnt_o); end
        tick();
        req_i = 3'b001;
        #2;
        checks++; if (gnt_o !== 3'b001) begin errors++; $display("FAIL hold_gnt2 got %b exp 001", gnt_o); end
        tick();
        req_i = '0; bank_gnt_i = 1'b0; bank_rvalid_i = 1'b1;
        #2;
        checks++; if (rvalid_o !== 3'b100) begin errors++; $display("FAIL hold_order1 got %b exp 100", rvalid_o); end
        tick();
        #2;
        checks++; if (rvalid_o !== 3'b001) begin errors++; $display("FAIL hold_order2 got %b exp 001", rvalid_o); end
        tick();
        idle();
    endtask

    task automatic test_empty_rvalid;
        do_reset();
        bank_rvalid_i = 1'b1;
        #2;
        checks++; if (rvalid_o !== 3'b000) begin errors++; $display("FAIL empty_rvalid got %b exp 000", rvalid_o); end
        tick();
        bank_rvalid_i = 1'b0; req_i = 3'b010; bank_gnt_i = 1'b1;
        tick();
        tick();
        #2;
        checks++; if (bank_req_o !== 1'b0) begin errors++; $display("FAIL empty_count got bank_req %b exp 0", bank_req_o); end
        req_i = '0; bank_rvalid_i = 1'b1;
        tick();
        tick();
        idle();
    endtask

    task automatic test_reset_midflight;
        do_reset();
        req_i = 3'b011; bank_gnt_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b1;
        #2;
        checks++; if (bank_req_o !== 1'b0) begin errors++; $display("FAIL mid_rst_req got %b exp 0", bank_req_o); end
        checks++; if (gnt_o !== 3'b000) begin errors++; $display("FAIL mid_rst_gnt got %b exp 000", gnt_o); end
        tick();
        rst_i = 1'b0; req_i = '0; bank_rvalid_i = 1'b1;
        #2;
        checks++; if (rvalid_o !== 3'b000) begin errors++; $display("FAIL mid_late_rvalid got %b exp 000", rvalid_o); end
        tick();
        bank_rvalid_i = 1'b0; req_i = 3'b110;
        #2;
        checks++; if (gnt_o !== 3'b010) begin errors++; $display("FAIL mid_ptr0 got %b exp 010", gnt_o); end
        tick();
        req_i = '0; bank_rvalid_i = 1'b1;
        #2;
        checks++; if (rvalid_o !== 3'b010) begin errors++; $display("FAIL mid_resp got %b exp 010", rvalid_o); end
        tick();
        idle();
    endtask

    task automatic test_push_pop;
        do_reset();
        req_i = 3'b001; bank_gnt_i = 1'b1;
        tick();
        req_i = 3'b100; bank_rvalid_i = 1'b1;
        #2;
        checks++; if (gnt_o !== 3'b100) begin errors++; $display("FAIL pp_gnt got %b exp 100", gnt_o); end
        checks++; if (rvalid_o !== 3'b001) begin errors++; $display("FAIL pp_old_id got %b exp 001", rvalid_o); end
        tick();
        req_i = '0;
        #2;
        checks++; if (rvalid_o !== 3'b100) begin errors++; $display("FAIL pp_second got %b exp 100", rvalid_o); end
        tick();
        #2;
        checks++; if (rvalid_o !== 3'b000) begin errors++; $display("FAIL pp_count1 got %b exp 000", rvalid_o); end
        tick();
        idle();
    endtask

    initial begin
        rst_i   = 1'b1;
        idle();
        addr_i  = {32'h0000_0C00, 32'h0000_0B00, 32'h0000_0A00};
        wdata_i = {32'h2222_0C00, 32'h1111_0B00, 32'h0000_0A00};
        be_i    = {4'hC, 4'h3, 4'h5};
        we_i    = 3'b010;
        tick();
        test_reset();
        test_round_robin();
        test_full();
        test_stall();
        test_hold();
        test_empty_rvalid();
        test_reset_midflight();
        test_push_pop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
